// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one external combinational ALU
// between two valid/ready requesters; operands and result are registered.
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SHW   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [2*SHW-1:0]   req_shamt,
  input  logic [5:0]         req_op,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_result,
  output logic               rsp_zero,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [SHW-1:0]     alu_shamt,
  output logic [2:0]         alu_op,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_zero,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  logic             last_grant_q;
  logic             owner_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [SHW-1:0]   alu_shamt_q;
  logic [2:0]       alu_op_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_zero_q;

  logic [1:0]       grant;
  logic             win;

  // On a tie the requester that did not win last time is preferred;
  // last_grant resets to 1 so requester 0 takes the first tie.
  always_comb begin
    grant = '0;
    if (rst_n && state_q == IDLE) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
        default: grant = '0;
      endcase
    end
  end

  assign win = grant[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_shamt_q  <= '0;
      alu_op_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|grant) begin
            alu_a_q      <= win ? req_a[2*WIDTH-1:WIDTH]   : req_a[WIDTH-1:0];
            alu_b_q      <= win ? req_b[2*WIDTH-1:WIDTH]   : req_b[WIDTH-1:0];
            alu_shamt_q  <= win ? req_shamt[2*SHW-1:SHW]   : req_shamt[SHW-1:0];
            alu_op_q     <= win ? req_op[5:3]              : req_op[2:0];
            owner_q      <= win;
            last_grant_q <= win;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_q <= alu_result;
          rsp_zero_q   <= alu_zero;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner_q]) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = grant;
  assign rsp_valid  = (rst_n && state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_shamt  = alu_shamt_q;
  assign alu_op     = alu_op_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed bench with a behavioural external ALU and a
// scoreboard of expected responses pushed on accept, popped on response handshake.
module tb_alu_share_arbiter;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned SHW   = 6;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic [2*SHW-1:0]   req_shamt;
  logic [5:0]         req_op;
  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_ready;
  logic [WIDTH-1:0]   rsp_result;
  logic               rsp_zero;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [SHW-1:0]     alu_shamt;
  logic [2:0]         alu_op;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_zero;
  logic               busy;

  alu_share_arbiter #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_shamt  (req_shamt),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_shamt  (alu_shamt),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // External combinational ALU
  always_comb begin
    case (alu_op)
      3'd0:    alu_result = alu_a + alu_b;
      3'd1:    alu_result = alu_a - alu_b;
      3'd2:    alu_result = alu_a & alu_b;
      3'd3:    alu_result = alu_a | alu_b;
      3'd4:    alu_result = alu_a ^ alu_b;
      3'd5:    alu_result = alu_a << alu_shamt;
      3'd6:    alu_result = alu_a >> alu_shamt;
      default: alu_result = alu_b;
    endcase
    alu_zero = (alu_result == '0);
  end

  typedef struct {
    int         id;
    logic [63:0] r;
    logic        z;
  } exp_t;

  exp_t        sb[$];
  int          grants[$];
  logic [63:0] exp_r [2];
  logic        exp_z [2];
  int          n_pass  = 0;
  int          n_fail  = 0;
  int          n_checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [5:0] sh);
    req_op[id*3 +: 3]       = op;
    req_a[id*64 +: 64]      = a;
    req_b[id*64 +: 64]      = b;
    req_shamt[id*6 +: 6]    = sh;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (!busy && sb.size() == 0) break;
      tick(1);
    end
    check("done_in_time", 64'(!busy && sb.size() == 0), 64'd1);
  endtask

  task automatic issue(input int id, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [5:0] sh,
                       input logic [63:0] er, input logic ez);
    exp_r[id] = er;
    exp_z[id] = ez;
    set_req(id, op, a, b, sh);
    req_valid     = '0;
    req_valid[id] = 1'b1;
    #1;
    for (int k = 0; k < 20 && !req_ready[id]; k++) tick(1);
    check("issue_ready", 64'(req_ready[id]), 64'd1);
    tick(1);
    req_valid = '0;
    check("issue_alu_op", 64'(alu_op), 64'(op));
    check("issue_alu_a", alu_a, a);
    check("issue_alu_b", alu_b, b);
    check("issue_alu_shamt", 64'(alu_shamt), 64'(sh));
    wait_done(10);
  endtask

  // Scoreboard monitor: sampled on the falling edge, ahead of the accepting edge
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.id = i;
          e.r  = exp_r[i];
          e.z  = exp_z[i];
          sb.push_back(e);
          grants.push_back(i);
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          if (sb.size() == 0) begin
            check("rsp_unexpected", 64'(i), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = sb.pop_front();
            check("rsp_owner", 64'(i), 64'(e.id));
            check("rsp_result", rsp_result, e.r);
            check("rsp_zero", 64'(rsp_zero), 64'(e.z));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic seen;
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_a     = '0;
    req_b     = '0;
    req_shamt = '0;
    req_op    = '0;
    rsp_ready = 2'b11;
    exp_r[0] = '0; exp_r[1] = '0;
    exp_z[0] = 1'b0; exp_z[1] = 1'b0;
    tick(2);

    // Reset state, with requests asserted during reset
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_alu_op", 64'(alu_op), 64'd0);
    check("rst_alu_a", alu_a, 64'd0);
    check("rst_result", rsp_result, 64'd0);
    req_valid = '0;
    rst_n = 1'b1;
    tick(1);

    // 1: single add, latency
    exp_r[0] = 64'd12; exp_z[0] = 1'b0;
    set_req(0, 3'd0, 64'd5, 64'd7, 6'd0);
    req_valid = 2'b01;
    #1;
    check("t1_ready", 64'(req_ready), 64'h1);
    tick(1);
    req_valid = '0;
    #1;
    check("t1_exec_busy", 64'(busy), 64'd1);
    check("t1_exec_rspv", 64'(rsp_valid), 64'd0);
    check("t1_exec_alu_a", alu_a, 64'd5);
    tick(1);
    check("t1_rspv", 64'(rsp_valid), 64'h1);
    check("t1_result", rsp_result, 64'd12);
    check("t1_zero", 64'(rsp_zero), 64'd0);
    tick(1);
    check("t1_idle", 64'(busy), 64'd0);

    // 2: continuous tie, alternating grants from reset
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    grants.delete();
    exp_r[0] = 64'd0;  exp_z[0] = 1'b1;
    exp_r[1] = 64'hFF; exp_z[1] = 1'b0;
    set_req(0, 3'd1, 64'd9, 64'd9, 6'd0);
    set_req(1, 3'd4, 64'hF0, 64'h0F, 6'd0);
    req_valid = 2'b11;
    for (int k = 0; k < 40 && grants.size() < 4; k++) tick(1);
    req_valid = '0;
    wait_done(20);
    for (int i = 0; i < 4; i++)
      check("t2_grant_order", 64'((i < grants.size()) ? grants[i] : -1), 64'(i % 2));

    // 3: backpressure on owner 0 while requester 1 waits
    rsp_ready = 2'b00;
    exp_r[0] = 64'd3; exp_z[0] = 1'b0;
    set_req(0, 3'd0, 64'd1, 64'd2, 6'd0);
    req_valid = 2'b01;
    #1;
    check("t3_ready", 64'(req_ready), 64'h1);
    tick(1);
    exp_r[1] = 64'h8000_0000_0000_0000; exp_z[1] = 1'b0;
    set_req(1, 3'd5, 64'd1, 64'd0, 6'd63);
    req_valid = 2'b10;
    #1;
    check("t3_exec_ready", 64'(req_ready), 64'd0);
    tick(1);
    for (int i = 0; i < 5; i++) begin
      rsp_ready = (i == 2) ? 2'b10 : 2'b00;
      #1;
      check("t3_hold_rspv", 64'(rsp_valid), 64'h1);
      check("t3_hold_result", rsp_result, 64'd3);
      check("t3_hold_ready", 64'(req_ready), 64'd0);
      check("t3_hold_busy", 64'(busy), 64'd1);
      tick(1);
    end
    rsp_ready = 2'b11;
    tick(1);
    check("t3_release_idle", 64'(busy), 64'd0);
    check("t3_release_grant1", 64'(req_ready), 64'h2);
    tick(1);
    req_valid = '0;

    // 4: shift to MSB (response checked by scoreboard), then passB of zero
    check("t4_alu_op", 64'(alu_op), 64'd5);
    check("t4_alu_shamt", 64'(alu_shamt), 64'd63);
    wait_done(10);
    issue(1, 3'd7, 64'hDEAD_BEEF_CAFE_F00D, 64'd0, 6'h2A, 64'd0, 1'b1);
    issue(0, 3'd3, 64'hFFFF_0000_0000_0000, 64'h0000_0000_0000_FFFF, 6'd0,
          64'hFFFF_0000_0000_FFFF, 1'b0);

    // 5: reset during EXEC discards the operation
    exp_r[0] = 64'h0F; exp_z[0] = 1'b0;
    set_req(0, 3'd2, 64'hFF, 64'h0F, 6'd0);
    req_valid = 2'b01;
    tick(1);
    req_valid = '0;
    check("t5_exec_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    sb.delete();
    #1;
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_rspv", 64'(rsp_valid), 64'd0);
    check("t5_alu_op", 64'(alu_op), 64'd0);
    check("t5_alu_a", alu_a, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (|rsp_valid) seen = 1'b1;
      tick(1);
    end
    check("t5_no_rsp", 64'(seen), 64'd0);
    exp_r[0] = 64'd30; exp_z[0] = 1'b0;
    exp_r[1] = 64'd40; exp_z[1] = 1'b0;
    set_req(0, 3'd0, 64'd10, 64'd20, 6'd0);
    set_req(1, 3'd0, 64'd15, 64'd25, 6'd0);
    req_valid = 2'b11;
    #1;
    check("t5_tie_req0", 64'(req_ready), 64'h1);
    tick(1);
    req_valid = '0;
    wait_done(10);

    // 6: requester 1 pulses only while busy
    grants.delete();
    exp_r[0] = 64'd10; exp_z[0] = 1'b0;
    exp_r[1] = 64'd99; exp_z[1] = 1'b0;
    set_req(0, 3'd0, 64'd9, 64'd1, 6'd0);
    set_req(1, 3'd7, 64'd0, 64'd99, 6'd0);
    req_valid = 2'b01;
    tick(1);
    req_valid = 2'b10;
    #1;
    check("t6_busy_ready", 64'(req_ready), 64'd0);
    tick(1);
    req_valid = '0;
    wait_done(10);
    tick(3);
    check("t6_grant_count", 64'(grants.size()), 64'd1);
    check("t6_grant_id", 64'((grants.size() > 0) ? grants[0] : -1), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
